// File: rtl/ysyx_22050550_div_ctrl.sv
// Divide-op sequencer between the EXU/WBU handshakes and a multi-cycle divider.
// Define YSYX_22050550_DIV_BYPASS_EN to resolve zero-divisor and signed-overflow ops without the divider.
module ysyx_22050550_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        div_valid,
  output logic        div_flush,
  output logic        div_w,
  output logic [1:0]  div_signed,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic        div_ready,
  input  logic        div_out_valid,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, KILL} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [63:0] src1_q, src2_q;
  logic [63:0] src1_ext, src2_ext;
  logic [63:0] div_res, div_res_fin;
  logic [63:0] by_res;
  logic        bypass;
  logic        accept;

  function automatic logic [63:0] ext32(input logic [31:0] v, input logic zext);
    return zext ? {32'h0, v} : {{32{v[31]}}, v};
  endfunction

  assign src1_ext = in_op[2] ? ext32(in_src1[31:0], in_op[0]) : in_src1;
  assign src2_ext = in_op[2] ? ext32(in_src2[31:0], in_op[0]) : in_src2;

`ifdef YSYX_22050550_DIV_BYPASS_EN
  logic        by_zero, by_ovf;
  logic [63:0] by_raw;
  // Operands are already extended, so a 64-bit compare covers both widths.
  assign by_zero = (src2_ext == 64'd0);
  assign by_ovf  = !in_op[0] && (src2_ext == {64{1'b1}}) &&
                   (in_op[2] ? (src1_ext == 64'hFFFF_FFFF_8000_0000)
                             : (src1_ext == 64'h8000_0000_0000_0000));
  assign bypass  = by_zero || by_ovf;
  assign by_raw  = in_op[1] ? (by_zero ? src1_ext : 64'd0)
                            : (by_zero ? {64{1'b1}} : src1_ext);
  assign by_res  = in_op[2] ? ext32(by_raw[31:0], 1'b0) : by_raw;
`else
  assign bypass = 1'b0;
  assign by_res = 64'd0;
`endif

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  // Flush is only meaningful while the divider is busy with our op.
  assign div_flush = (state == KILL) && !div_ready;
  assign div_valid = (state == WAIT) || div_flush;

  assign div_w        = op_q[2];
  assign div_signed   = op_q[0] ? 2'b00 : 2'b11;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;

  assign div_res     = op_q[1] ? div_remainder : div_quotient;
  assign div_res_fin = op_q[2] ? ext32(div_res[31:0], 1'b0) : div_res;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 3'b000;
      src1_q   <= 64'd0;
      src2_q   <= 64'd0;
      out_data <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            src1_q <= src1_ext;
            src2_q <= src2_ext;
            if (bypass) begin
              out_data <= by_res;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A result arriving with flush is dropped; the divider is already idle.
          if (flush) begin
            state <= div_out_valid ? IDLE : KILL;
          end else if (div_out_valid) begin
            out_data <= div_res_fin;
            state    <= DONE;
          end
        end
        DONE: begin
          if (flush || out_ready) state <= IDLE;
        end
        KILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050550_div_ctrl.md
YSYX_22050550_DIV_CTRL -- requirements
Module: ysyx_22050550_div_ctrl

Interface
REQ-001 The block SHALL have these ports: clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 The block SHALL have these ports: in_valid  in  1  EXU presents a divide op; in_ready  out  1  op accepted this cycle.
REQ-004 The block SHALL have these ports: in_op  in  3  [0]=unsigned, [1]=remainder, [2]=word (32-bit) op; in_src1/in_src2  in  64  dividend/divisor.
REQ-005 The block SHALL have these ports: flush  in  1  kill the in-flight op, no result produced.
REQ-006 The block SHALL have these ports: out_valid  out  1  result valid; out_ready  in  1  WBU accepts; out_data  out  64  final result.
REQ-007 The block SHALL have these ports: div_valid, div_flush, div_w  out  1 each; div_signed  out  2 (2'b11 signed, 2'b00 unsigned); div_dividend, div_divisor  out  64.
REQ-008 The block SHALL have these ports: div_ready, div_out_valid  in  1 each; div_quotient, div_remainder  in  64.

Function
REQ-009 The block SHALL implement states IDLE, WAIT, DONE and KILL.
REQ-010 in_ready SHALL be 1 only in IDLE; an op is accepted when in_valid && in_ready, and its operands and in_op are latched into internal registers.
REQ-011 For word ops, latched operands SHALL be sign-extended from bit 31 (signed) or zero-extended from bit 31 (unsigned) before being driven to the divider.
REQ-012 On acceptance of a non-bypassed op, IDLE->WAIT; div_valid SHALL be 1 for every cycle in WAIT, with div_w, div_signed, div_dividend and div_divisor held constant.
REQ-013 div_valid SHALL remain high through the cycle in which div_out_valid=1, because the divider advances only while div_valid is high.
REQ-014 In that cycle the block SHALL capture div_quotient (in_op[1]=0) or div_remainder (in_op[1]=1) and go WAIT->DONE.
REQ-015 div_valid SHALL be 0 in DONE and IDLE so that the divider does not restart.
REQ-016 For word ops, the captured value SHALL be sign-extended from bit 31 into out_data.
REQ-017 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until out_valid && out_ready, after which the state is IDLE.
REQ-018 flush in WAIT SHALL move to KILL; in KILL the block drives div_valid=1 and div_flush=1 for exactly one cycle, then goes to IDLE with no out_valid.
REQ-019 flush in DONE SHALL drop the result and return to IDLE.
REQ-020 flush in IDLE SHALL have no effect, and a simultaneous in_valid is not accepted.
REQ-021 flush and div_out_valid in the same WAIT cycle: flush SHALL win, the result SHALL be discarded, no KILL cycle is issued, and the next state is IDLE.
REQ-022 div_flush SHALL never be asserted while div_ready=1.
REQ-023 Divider-path latency SHALL be 1 cycle from div_out_valid to out_valid.

Reset
REQ-024 On reset: state=IDLE; in_ready=1; out_valid=0; div_valid=0; div_flush=0; out_data=0; latched operands=0.
REQ-025 Reset asserted mid-operation SHALL abort immediately; the divider is reset by the same reset and no flush cycle is issued.

Configuration
REQ-026 The macro YSYX_22050550_DIV_BYPASS_EN SHALL control the special-case bypass.
REQ-027 With YSYX_22050550_DIV_BYPASS_EN defined, a zero divisor (in the operand width) SHALL bypass the divider: IDLE->DONE in 1 cycle, with quotient=all ones (sign-extended for word ops) and remainder=dividend.
REQ-028 With the macro defined, signed overflow (most-negative / -1) SHALL also bypass: quotient=dividend, remainder=0.
REQ-029 With the macro defined, div_valid SHALL never be asserted for bypassed ops.
REQ-030 Without the macro, every op SHALL go through the divider, and out_data is whatever the divider returns.

Verification
REQ-031 div 100/7, 64-bit signed: out_data=14 after div_out_valid+1; div_valid high continuously until then.
REQ-032 rem -7/2, signed: out_data=0xFFFFFFFFFFFFFFFF (-1); remu 7/2: out_data=1.
REQ-033 divuw 0xFFFFFFFF/1: div_dividend=0x00000000FFFFFFFF and out_data=0xFFFFFFFFFFFFFFFF.
REQ-034 With YSYX_22050550_DIV_BYPASS_EN: div 5/0 gives out_data=0xFFFFFFFFFFFFFFFF one cycle after acceptance, div_valid never set; div 0x8000000000000000/-1 gives out_data=0x8000000000000000.
REQ-035 flush 10 cycles into WAIT: exactly one cycle of div_valid=div_flush=1, then in_ready=1, no out_valid; a following div 9/3 returns 3.
REQ-036 Hold out_ready=0 for 5 cycles in DONE: out_data stable and no new op accepted; reset asserted mid-WAIT: outputs take reset values asynchronously.
